hci_router_splitter: RTL
========================

Name: hci_router_splitter

Overview:
Upstream stage of the HCI router reorder stage. It accepts one wide HCI request (NB_CHAN x 32 bit) and registers it. It then issues that request as NB_CHAN lockstep 32-bit lane requests, together with the bank rotation index order_o. The fixed-latency-1 lane responses are collected into a wide response register, which is held until the wide initiator accepts it. One transaction is outstanding at a time.

Parameters:
NB_CHAN, 4, number of 32-bit lanes; power of 2, >=2
NB_BANKS, 8, number of downstream banks; power of 2, >= NB_CHAN; width of order_o is log2(NB_BANKS)
WRITE_RESP, 0, 1: writes also produce a wide response beat; 0: writes complete on grant

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
clear_i  in  1  synchronous clear to IDLE
tgt_req_i  in  1  wide request
tgt_gnt_o  out  1  wide grant
tgt_add_i  in  32  byte address; bits [1:0] ignored
tgt_wen_i  in  1  1=read, 0=write
tgt_be_i  in  4*NB_CHAN  byte enables
tgt_data_i  in  32*NB_CHAN  write data
tgt_r_data_o  out  32*NB_CHAN  read data
tgt_r_valid_o  out  1  response valid
tgt_r_ready_i  in  1  response accept
lane_req_o  out  NB_CHAN  lane requests, always all equal
lane_add_o  out  32*NB_CHAN  lane i address
lane_wen_o  out  NB_CHAN  lane wen
lane_be_o  out  4*NB_CHAN  lane byte enables
lane_data_o  out  32*NB_CHAN  lane write data
lane_gnt_i  in  NB_CHAN  only bit 0 is used (downstream broadcasts its grant)
lane_r_data_i  in  32*NB_CHAN  lane read data
lane_r_valid_i  in  NB_CHAN  only bit 0 is used
order_o  out  log2(NB_BANKS)  rotation index for the reorder stage
err_o  out  1  sticky protocol error (optional feature)

Behaviour:
- FSM states:
  - IDLE: tgt_gnt_o=1. On tgt_req_i, capture add/wen/be/data into request registers, go to ISSUE.
  - ISSUE: lane_req_o all 1 from the registers. On lane_gnt_i[0]:
    - read, or write with WRITE_RESP=1: go to RESP.
    - write with WRITE_RESP=0: go to IDLE.
  - RESP: on lane_r_valid_i[0], capture lane_r_data_i into the response register, go to HOLD. Otherwise stay in RESP.
  - HOLD: tgt_r_valid_o=1. On tgt_r_ready_i, go to IDLE.
- tgt_gnt_o is asserted in IDLE only. A new request is never accepted in the same cycle as a HOLD release.
- Latency (read, no stalls):
  - accept at cycle N;
  - lane_req_o in N+1, granted in N+1;
  - lane_r_valid_i in N+2;
  - tgt_r_valid_o from N+3.
- Lane address: lane_add_o[i] = {tgt_add[31:2] + i, 2'b00}, modulo 2^32; wrap at 0xFFFFFFFC is allowed.
- order_o = tgt_add[2 +: log2(NB_BANKS)] from the request register. It is held stable from ISSUE through RESP.
- Lane slicing: lane_be_o and lane_data_o lane i = slice i of the registered be/data. lane_wen_o = registered wen replicated.
- Outputs outside ISSUE: lane_req_o=0; the other lane outputs hold their register values.
- Write response data is 0.
- Reset values: tgt_gnt_o=1; all other outputs 0; FSM in IDLE; all registers 0.
- clear_i has priority over all transitions:
  - FSM goes to IDLE; the request register is kept, the response register is zeroed, err_o is cleared.
  - A pending HOLD response is dropped.
- Reset mid-operation: same effect as clear_i, but asynchronous and with the request register also zeroed.

Optional Feature:
HCI_ROUTER_SPLITTER_ERR_EN
- Defined: err_o sets (sticky until clear_i or reset) on any of:
  - lane_r_valid_i[0] in any state other than RESP;
  - any lane_r_valid_i bit differing from bit 0;
  - any lane_gnt_i bit differing from bit 0 while in ISSUE.
- Not defined: err_o tied to 0 and no checking logic is generated.

Decomposition:
- Package hci_router_splitter_pkg:
  - state enum (IDLE, ISSUE, RESP, HOLD);
  - constant LANE_BYTES=4;
  - function computing order_o width from NB_BANKS.
- One sub-module hci_router_splitter_addr_gen: combinational lane address generation plus order_o extraction.

Test Plan:
All scenarios use NB_CHAN=4, NB_BANKS=8.
- Read at 0x1C, grant immediate:
  - N+1: order_o=7, lane_add_o = 0x1C, 0x20, 0x24, 0x28;
  - tgt_r_valid_o in N+3 with the lane data concatenated, lane 0 in the LSBs.
- Write at 0x40 with WRITE_RESP=0, be=0xF0F0:
  - lane_be_o = 0x0,0xF,0x0,0xF for lanes 0..3; tgt_gnt_o back to 1 one cycle after the lane grant; tgt_r_valid_o never 1.
- lane_gnt_i[0] held low for 5 cycles:
  - lane_req_o stays 1 with stable addresses and order_o; tgt_gnt_o=0 throughout.
- tgt_r_ready_i low for 4 cycles in HOLD:
  - tgt_r_valid_o and tgt_r_data_o stable; a second tgt_req_i is not granted until the cycle after the release.
- Address 0xFFFFFFF8:
  - lane addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4; order_o=6.
- clear_i asserted in RESP, then rst_i pulsed in ISSUE:
  - both return to IDLE with tgt_gnt_o=1 and tgt_r_valid_o=0;
  - with HCI_ROUTER_SPLITTER_ERR_EN, a late lane_r_valid_i sets err_o=1.

Source files
------------

// File: rtl/hci_router_splitter_pkg.sv
// HCI router splitter: shared types and constants.
// State encoding, lane geometry and order-width helper.
package hci_router_splitter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP,
        HOLD
    } state_e;

    localparam int LANE_BYTES = 4;
    localparam int LANE_BITS  = 8 * LANE_BYTES;

    // Width of the bank rotation index; never below 1 bit.
    function automatic int order_width(input int nb_banks);
        return (nb_banks > 1) ? $clog2(nb_banks) : 1;
    endfunction

endpackage

// File: rtl/hci_router_splitter_addr_gen.sv
// HCI router splitter: per-lane word addresses and bank rotation.
// Lane i targets the i-th consecutive word; wraps modulo 2^32.
module hci_router_splitter_addr_gen
    import hci_router_splitter_pkg::*;
#(
    parameter int NB_CHAN  = 4,
    parameter int NB_BANKS = 8,
    parameter int OW       = order_width(NB_BANKS)
) (
    input  logic [31:0]             add_i,
    output logic [32*NB_CHAN-1:0]   lane_add_o,
    output logic [OW-1:0]           order_o
);

    logic [29:0] word;
    logic        unused_lsb;

    assign word       = add_i[31:2];
    assign unused_lsb = ^add_i[1:0];

    // Consecutive word addresses, one per lane.
    always_comb begin
        lane_add_o = '0;
        for (int i = 0; i < NB_CHAN; i++) begin
            lane_add_o[i*32 +: 32] =
                {word + 30'(i), 2'b00};
        end
    end

    assign order_o = add_i[2 +: OW];

endmodule

// File: rtl/hci_router_splitter.sv
// HCI router splitter: one wide request -> NB_CHAN lockstep lanes.
// Optional sticky checker: define HCI_ROUTER_SPLITTER_ERR_EN.
module hci_router_splitter
    import hci_router_splitter_pkg::*;
#(
    parameter int NB_CHAN    = 4,
    parameter int NB_BANKS   = 8,
    parameter int WRITE_RESP = 0,
    parameter int OW         = order_width(NB_BANKS)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   tgt_req_i,
    output logic                   tgt_gnt_o,
    input  logic [31:0]            tgt_add_i,
    input  logic                   tgt_wen_i,
    input  logic [4*NB_CHAN-1:0]   tgt_be_i,
    input  logic [32*NB_CHAN-1:0]  tgt_data_i,
    output logic [32*NB_CHAN-1:0]  tgt_r_data_o,
    output logic                   tgt_r_valid_o,
    input  logic                   tgt_r_ready_i,
    output logic [NB_CHAN-1:0]     lane_req_o,
    output logic [32*NB_CHAN-1:0]  lane_add_o,
    output logic [NB_CHAN-1:0]     lane_wen_o,
    output logic [4*NB_CHAN-1:0]   lane_be_o,
    output logic [32*NB_CHAN-1:0]  lane_data_o,
    input  logic [NB_CHAN-1:0]     lane_gnt_i,
    input  logic [32*NB_CHAN-1:0]  lane_r_data_i,
    input  logic [NB_CHAN-1:0]     lane_r_valid_i,
    output logic [OW-1:0]          order_o,
    output logic                   err_o
);

    localparam bit WR_RESP = (WRITE_RESP != 0);

    state_e                  state_q;
    logic                    gnt_q;
    logic                    lreq_q;
    logic                    rvalid_q;
    logic [32*NB_CHAN-1:0]   rdata_q;

    logic [32*NB_CHAN-1:0]   ladd_q;
    logic [OW-1:0]           order_q;
    logic                    wen_q;
    logic [4*NB_CHAN-1:0]    be_q;
    logic [32*NB_CHAN-1:0]   data_q;

    logic [32*NB_CHAN-1:0]   ladd_d;
    logic [OW-1:0]           order_d;
    logic                    accept;

    hci_router_splitter_addr_gen #(
        .NB_CHAN  (NB_CHAN),
        .NB_BANKS (NB_BANKS),
        .OW       (OW)
    ) i_addr_gen (
        .add_i      (tgt_add_i),
        .lane_add_o (ladd_d),
        .order_o    (order_d)
    );

    assign accept = (state_q == IDLE)
                  && tgt_req_i
                  && !clear_i;

    // Request register: lane addresses are precomputed at accept.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ladd_q  <= '0;
            order_q <= '0;
            wen_q   <= 1'b0;
            be_q    <= '0;
            data_q  <= '0;
        end else if (accept) begin
            ladd_q  <= ladd_d;
            order_q <= order_d;
            wen_q   <= tgt_wen_i;
            be_q    <= tgt_be_i;
            data_q  <= tgt_data_i;
        end
    end

    // Transaction FSM with registered handshake outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b1;
            lreq_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else if (clear_i) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b1;
            lreq_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (tgt_req_i) begin
                        state_q <= ISSUE;
                        gnt_q   <= 1'b0;
                        lreq_q  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (lane_gnt_i[0]) begin
                        lreq_q <= 1'b0;
                        if (wen_q || WR_RESP) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= IDLE;
                            gnt_q   <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (lane_r_valid_i[0]) begin
                        state_q  <= HOLD;
                        rvalid_q <= 1'b1;
                        rdata_q  <= wen_q ? lane_r_data_i
                                          : '0;
                    end
                end
                HOLD: begin
                    if (tgt_r_ready_i) begin
                        state_q  <= IDLE;
                        rvalid_q <= 1'b0;
                        gnt_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 1'b1;
                    lreq_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tgt_gnt_o     = gnt_q;
    assign tgt_r_valid_o = rvalid_q;
    assign tgt_r_data_o  = rdata_q;
    assign lane_req_o    = {NB_CHAN{lreq_q}};
    assign lane_add_o    = ladd_q;
    assign lane_wen_o    = {NB_CHAN{wen_q}};
    assign lane_be_o     = be_q;
    assign lane_data_o   = data_q;
    assign order_o       = order_q;

`ifdef HCI_ROUTER_SPLITTER_ERR_EN
    logic err_q;
    logic err_set;

    // Protocol violations: stray response or lanes out of lockstep.
    always_comb begin
        err_set = 1'b0;
        if (lane_r_valid_i[0] && state_q != RESP)
            err_set = 1'b1;
        if (lane_r_valid_i !=
            {NB_CHAN{lane_r_valid_i[0]}})
            err_set = 1'b1;
        if (state_q == ISSUE &&
            lane_gnt_i != {NB_CHAN{lane_gnt_i[0]}})
            err_set = 1'b1;
    end

    // Sticky error flag, dropped only by clear or reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            err_q <= 1'b0;
        else if (clear_i)
            err_q <= 1'b0;
        else if (err_set)
            err_q <= 1'b1;
    end

    assign err_o = err_q;
`else
    logic unused_lanes;

    assign unused_lanes = ^{lane_gnt_i[NB_CHAN-1:1],
                            lane_r_valid_i[NB_CHAN-1:1]};
    assign err_o = 1'b0;
`endif

endmodule
